// File: rtl/obc_challenge_monitor.sv
// rtl/obc_challenge_monitor.sv - OBC challenge-response monitor (optional LFSR questions via CHK_LFSR_QUESTION_EN)
module obc_challenge_monitor #(
  parameter int W           = 4,
  parameter int ROUND_LEN   = 10,
  parameter int PASS_MIN    = 10,
  parameter int TIMEOUT     = 16,
  parameter int MAX_STRIKES = 3,
  parameter int INTERVAL    = 100,
  parameter int SEED        = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  output logic                             q_valid,
  output logic [W-1:0]                     question,
  input  logic                             a_valid,
  input  logic [W-1:0]                     answer_obc,
  output logic                             round_done,
  output logic                             round_pass,
  output logic [$clog2(ROUND_LEN+1)-1:0]   pass_cnt,
  output logic [$clog2(MAX_STRIKES+1)-1:0] strikes,
  output logic                             override,
  output logic                             obc_reset
);

  localparam int PW   = $clog2(ROUND_LEN + 1);
  localparam int SW   = $clog2(MAX_STRIKES + 1);
  localparam int CMAX = (TIMEOUT > INTERVAL) ? TIMEOUT : INTERVAL;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ASK, S_WAIT, S_EVAL, S_VALID, S_SHUTDOWN
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;        // WAIT timer, reused as VALID hold counter
  logic [PW-1:0] idx;        // question index within the round
  logic          ans_ok;     // latched verdict for the current question

`ifdef CHK_LFSR_QUESTION_EN
  // Feedback taps of a maximal-length polynomial for each supported width.
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      2:       lfsr_taps = 32'h0003;
      3:       lfsr_taps = 32'h0006;
      4:       lfsr_taps = 32'h000C;
      5:       lfsr_taps = 32'h0014;
      6:       lfsr_taps = 32'h0030;
      7:       lfsr_taps = 32'h0060;
      8:       lfsr_taps = 32'h00B8;
      9:       lfsr_taps = 32'h0110;
      10:      lfsr_taps = 32'h0240;
      11:      lfsr_taps = 32'h0500;
      12:      lfsr_taps = 32'h0829;
      13:      lfsr_taps = 32'h100D;
      14:      lfsr_taps = 32'h2015;
      15:      lfsr_taps = 32'h6000;
      16:      lfsr_taps = 32'hD008;
      default: lfsr_taps = 32'h3 << (w - 2);
    endcase
  endfunction

  localparam logic [31:0]  TAPS32 = lfsr_taps(W);
  localparam logic [W-1:0] TAPS   = TAPS32[W-1:0];

  function automatic logic [W-1:0] next_question(input logic [W-1:0] q);
    next_question = {q[W-2:0], ^(q & TAPS)};
  endfunction
`else
  function automatic logic [W-1:0] next_question(input logic [W-1:0] q);
    next_question = q + W'(1);
  endfunction
`endif

  // Bit 0 is the inverse of q[0]; every higher bit is q[i] xor its lower neighbour.
  logic [W-1:0]  exp_ans;
  logic          timed_out, last_q, round_ok, shut;
  logic [PW-1:0] pass_cnt_new;
  logic [SW-1:0] strikes_new;

  assign exp_ans      = question ^ {question[W-2:0], 1'b1};
  assign timed_out    = (cnt == CW'(TIMEOUT));
  assign last_q       = (idx == PW'(ROUND_LEN - 1));
  assign pass_cnt_new = (ans_ok && (pass_cnt < PW'(ROUND_LEN))) ? pass_cnt + PW'(1) : pass_cnt;
  assign round_ok     = (pass_cnt_new >= PW'(PASS_MIN));
  assign strikes_new  = strikes + SW'(1);
  assign shut         = !round_ok && (strikes_new == SW'(MAX_STRIKES));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; dropping enable aborts everything except SHUTDOWN.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (enable) state_nxt = S_ASK;
      S_ASK:      state_nxt = enable ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (!enable)                    state_nxt = S_IDLE;
        else if (a_valid || timed_out)  state_nxt = S_EVAL;
      end
      S_EVAL: begin
        if (!enable)      state_nxt = S_IDLE;
        else if (!last_q) state_nxt = S_ASK;
        else if (round_ok) state_nxt = S_VALID;
        else if (shut)    state_nxt = S_SHUTDOWN;
        else              state_nxt = S_ASK;
      end
      S_VALID: begin
        if (!enable)                      state_nxt = S_IDLE;
        else if (cnt == CW'(INTERVAL))    state_nxt = S_ASK;
      end
      S_SHUTDOWN: state_nxt = S_SHUTDOWN;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    q_valid  = (state == S_ASK);
    override = (state == S_SHUTDOWN);
  end

  // Datapath: timers, question generator, scoring and round bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      question   <= W'(SEED);
      cnt        <= '0;
      idx        <= '0;
      ans_ok     <= 1'b0;
      pass_cnt   <= '0;
      strikes    <= '0;
      round_done <= 1'b0;
      round_pass <= 1'b0;
      obc_reset  <= 1'b0;
    end else begin
      round_done <= 1'b0;
      obc_reset  <= 1'b0;
      case (state)
        S_IDLE: begin
          pass_cnt <= '0;
          idx      <= '0;
        end
        S_ASK: begin
          cnt <= CW'(1);
          // The previous round's count stays visible through the first ASK of the next round.
          if (idx == '0) pass_cnt <= '0;
        end
        S_WAIT: begin
          if (a_valid)        ans_ok <= (answer_obc == exp_ans);
          else if (timed_out) ans_ok <= 1'b0;
          else                cnt    <= cnt + CW'(1);
        end
        S_EVAL: begin
          if (enable) begin
            pass_cnt <= pass_cnt_new;
            question <= next_question(question);
            if (!last_q) begin
              idx <= idx + PW'(1);
            end else begin
              idx        <= '0;
              round_done <= 1'b1;
              round_pass <= round_ok;
              cnt        <= CW'(1);
              if (round_ok) strikes <= '0;
              else          strikes <= strikes_new;
              if (shut)     obc_reset <= 1'b1;
            end
          end
        end
        S_VALID: cnt <= cnt + CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_obc_challenge_monitor.sv
// tb/tb_obc_challenge_monitor.sv - self-checking bench for obc_challenge_monitor
module tb_obc_challenge_monitor;

  localparam int W = 4, RL = 2, PM = 2, TO = 4, MS = 2, IV = 3, SD = 7;

  logic       clk = 1'b0;
  logic       reset, enable, a_valid;
  logic [3:0] answer_obc;
  logic       q_valid, round_done, round_pass, override, obc_reset;
  logic [3:0] question;
  logic [1:0] pass_cnt, strikes;

  int n_checks = 0;
  int n_err    = 0;

  obc_challenge_monitor #(
    .W(W), .ROUND_LEN(RL), .PASS_MIN(PM), .TIMEOUT(TO),
    .MAX_STRIKES(MS), .INTERVAL(IV), .SEED(SD)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .q_valid(q_valid),
    .question(question), .a_valid(a_valid), .answer_obc(answer_obc),
    .round_done(round_done), .round_pass(round_pass), .pass_cnt(pass_cnt),
    .strikes(strikes), .override(override), .obc_reset(obc_reset)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, errors so far %0d", n_err);
    $fatal(1);
  end

  typedef struct {
    bit       en, av;
    bit [3:0] ans;
    bit       qv;
    bit [3:0] q;
    bit       rd, rp;
    bit [1:0] pc, st;
    bit       ov, orst;
  } vec_t;

  vec_t tv[25];

  function automatic logic [3:0] expf(input logic [3:0] q);
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (i == 0) ? ~q[0] : (q[i] ^ q[i-1]);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; a_valid = 1'b0; answer_obc = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_ask();
    for (int k = 0; k < 20 && !q_valid; k++) step();
    chk("ask_seen", q_valid, 1);
  endtask

  // Starting in an ASK cycle: answer at WAIT cycle j (j > TO means never answer).
  // Returns one cycle after the EVAL cycle.
  task automatic ask_answer(input int j, input logic [3:0] ans, input bit garbage);
    int tw;
    if (garbage) begin a_valid = 1'b1; answer_obc = ~ans; end
    step();
    a_valid = 1'b0;
    tw = (j > TO) ? TO : j;
    for (int t = 1; t < tw; t++) step();
    if (j <= TO) begin a_valid = 1'b1; answer_obc = ans; end
    step();
    a_valid = 1'b0;
    step();
  endtask

  initial begin
    //            en av ans  qv q   rd rp pc st ov or
    tv[0]  = '{1, 0, 0,   1, 7,  0, 0, 0, 0, 0, 0};
    tv[1]  = '{1, 0, 0,   0, 7,  0, 0, 0, 0, 0, 0};
    tv[2]  = '{1, 1, 8,   0, 7,  0, 0, 0, 0, 0, 0};
    tv[3]  = '{1, 0, 0,   1, 8,  0, 0, 1, 0, 0, 0};
    tv[4]  = '{1, 0, 0,   0, 8,  0, 0, 1, 0, 0, 0};
    tv[5]  = '{1, 1, 9,   0, 8,  0, 0, 1, 0, 0, 0};
    tv[6]  = '{1, 0, 0,   0, 9,  1, 1, 2, 0, 0, 0};
    tv[7]  = '{1, 0, 0,   0, 9,  0, 1, 2, 0, 0, 0};
    tv[8]  = '{1, 0, 0,   0, 9,  0, 1, 2, 0, 0, 0};
    tv[9]  = '{1, 0, 0,   1, 9,  0, 1, 2, 0, 0, 0};
    tv[10] = '{1, 0, 0,   0, 9,  0, 1, 0, 0, 0, 0};
    tv[11] = '{1, 0, 0,   0, 9,  0, 1, 0, 0, 0, 0};
    tv[12] = '{1, 0, 0,   0, 9,  0, 1, 0, 0, 0, 0};
    tv[13] = '{1, 0, 0,   0, 9,  0, 1, 0, 0, 0, 0};
    tv[14] = '{1, 0, 0,   0, 9,  0, 1, 0, 0, 0, 0};
    tv[15] = '{1, 0, 0,   1, 10, 0, 1, 0, 0, 0, 0};
    tv[16] = '{1, 0, 0,   0, 10, 0, 1, 0, 0, 0, 0};
    tv[17] = '{1, 1, 0,   0, 10, 0, 1, 0, 0, 0, 0};
    tv[18] = '{1, 0, 0,   1, 11, 1, 0, 0, 1, 0, 0};
    tv[19] = '{1, 0, 0,   0, 11, 0, 0, 0, 1, 0, 0};
    tv[20] = '{1, 1, 12,  0, 11, 0, 0, 0, 1, 0, 0};
    tv[21] = '{1, 0, 0,   1, 12, 0, 0, 1, 1, 0, 0};
    tv[22] = '{1, 0, 0,   0, 12, 0, 0, 1, 1, 0, 0};
    tv[23] = '{1, 1, 5,   0, 12, 0, 0, 1, 1, 0, 0};
    tv[24] = '{1, 0, 0,   0, 13, 1, 1, 2, 0, 0, 0};

    // Reset state.
    do_reset();
    chk("rst_q_valid", q_valid, 0);
    chk("rst_question", question, SD);
    chk("rst_round_done", round_done, 0);
    chk("rst_round_pass", round_pass, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_strikes", strikes, 0);
    chk("rst_override", override, 0);
    chk("rst_obc_reset", obc_reset, 0);

    // Cycle table: pass round, VALID hold, timeout, failed round, passing retry.
    for (int i = 0; i < 25; i++) begin
      enable = tv[i].en; a_valid = tv[i].av; answer_obc = tv[i].ans;
      step();
      chk($sformatf("tv%0d_q_valid", i),    q_valid,    tv[i].qv);
      chk($sformatf("tv%0d_question", i),   question,   tv[i].q);
      chk($sformatf("tv%0d_round_done", i), round_done, tv[i].rd);
      chk($sformatf("tv%0d_round_pass", i), round_pass, tv[i].rp);
      chk($sformatf("tv%0d_pass_cnt", i),   pass_cnt,   tv[i].pc);
      chk($sformatf("tv%0d_strikes", i),    strikes,    tv[i].st);
      chk($sformatf("tv%0d_override", i),   override,   tv[i].ov);
      chk($sformatf("tv%0d_obc_reset", i),  obc_reset,  tv[i].orst);
    end
    a_valid = 1'b0;

    // Two failed rounds -> SHUTDOWN, then everything ignored until reset.
    do_reset();
    enable = 1'b1;
    step();
    chk("sd_ask", q_valid, 1);
    ask_answer(1, 4'h0, 1'b0);
    ask_answer(2, 4'h0, 1'b0);
    chk("sd_rd1", round_done, 1);
    chk("sd_rp1", round_pass, 0);
    chk("sd_st1", strikes, 1);
    chk("sd_retry_ask", q_valid, 1);
    chk("sd_retry_q", question, 9);
    ask_answer(3, 4'h0, 1'b0);
    ask_answer(1, 4'h0, 1'b0);
    chk("sd_rd2", round_done, 1);
    chk("sd_st2", strikes, 2);
    chk("sd_obc_reset", obc_reset, 1);
    chk("sd_override", override, 1);
    for (int k = 0; k < 6; k++) begin
      enable = 1'($urandom_range(0, 1)); a_valid = 1'b1; answer_obc = 4'($urandom);
      step();
      chk("sd_hold_override", override, 1);
      chk("sd_hold_obc_reset", obc_reset, 0);
      chk("sd_hold_q_valid", q_valid, 0);
      chk("sd_hold_round_done", round_done, 0);
    end
    a_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("sd_reset_override", override, 0);
    chk("sd_reset_question", question, SD);
    chk("sd_reset_strikes", strikes, 0);

    // enable dropped during WAIT: no round_done, strikes kept, question not rewound.
    do_reset();
    enable = 1'b1;
    step();
    ask_answer(1, 4'h0, 1'b0);
    ask_answer(1, 4'h0, 1'b0);
    chk("ab_st1", strikes, 1);
    ask_answer(1, expf(4'h9), 1'b0);
    chk("ab_ask_a", q_valid, 1);
    chk("ab_q_a", question, 10);
    step();
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("ab_idle_q_valid", q_valid, 0);
      chk("ab_idle_round_done", round_done, 0);
      chk("ab_idle_strikes", strikes, 1);
    end
    chk("ab_idle_pass_cnt", pass_cnt, 0);
    enable = 1'b1;
    step();
    chk("ab_resume_ask", q_valid, 1);
    chk("ab_resume_q", question, 10);

    // Counter sequence wraps from 4'hF to 4'h0.
    do_reset();
    enable = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      logic [3:0] mq;
      mq = 4'((SD + i) % 16);
      wait_ask();
      chk("wrap_question", question, mq);
      ask_answer(1, expf(mq), 1'b0);
    end

    // Randomised rounds against a transaction-level model.
    for (int run = 0; run < 4; run++) begin
      logic [3:0] mq;
      int         st_m;
      do_reset();
      enable = 1'b1;
      step();
      mq   = 4'(SD);
      st_m = 0;
      for (int r = 0; r < 10; r++) begin
        int pc_m;
        pc_m = 0;
        for (int i = 0; i < RL; i++) begin
          int         j;
          bit         corr;
          logic [3:0] ans;
          wait_ask();
          chk("rnd_question", question, mq);
          j    = $urandom_range(1, TO + 1);
          corr = (j <= TO) && ($urandom_range(0, 3) != 0);
          ans  = corr ? expf(mq) : (expf(mq) ^ 4'($urandom_range(1, 15)));
          ask_answer(j, ans, 1'($urandom_range(0, 1)));
          if (corr) pc_m++;
          mq = mq + 4'd1;
          if (i < RL - 1) begin
            chk("rnd_next_ask", q_valid, 1);
            chk("rnd_no_round_done", round_done, 0);
          end
        end
        if (pc_m >= PM) st_m = 0;
        else            st_m++;
        chk("rnd_round_done", round_done, 1);
        chk("rnd_round_pass", round_pass, (pc_m >= PM) ? 1 : 0);
        chk("rnd_pass_cnt", pass_cnt, pc_m);
        chk("rnd_strikes", strikes, st_m);
        if (st_m == MS) begin
          chk("rnd_obc_reset", obc_reset, 1);
          chk("rnd_override", override, 1);
          step();
          chk("rnd_obc_reset_pulse", obc_reset, 0);
          chk("rnd_override_held", override, 1);
          break;
        end else if (pc_m >= PM) begin
          for (int k = 1; k < IV; k++) begin
            step();
            chk("rnd_valid_hold", q_valid, 0);
            chk("rnd_valid_rd", round_done, 0);
          end
          step();
          chk("rnd_valid_end", q_valid, 1);
        end else begin
          chk("rnd_retry_ask", q_valid, 1);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
